// File: rtl/rtc_read_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rtc_read_sequencer_if : RTC multiplexed AD bus plus display-side burst link
// Rev 1.0
// ---------------------------------------------------------------------------
interface rtc_read_sequencer_if;
    logic       tick;
    logic [7:0] ad_i;
    logic [7:0] ad_o;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic       busy;
    logic       inicioSecuencia;
    logic [7:0] datoRTC;

    modport master (
        input  tick, ad_i,
        output ad_o, ad_oe, cs_n, rd_n, wr_n, a_d, busy, inicioSecuencia, datoRTC
    );

    modport slave (
        output tick, ad_i,
        input  ad_o, ad_oe, cs_n, rd_n, wr_n, a_d, busy, inicioSecuencia, datoRTC
    );
endinterface
`default_nettype wire

// File: rtl/rtc_read_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rtc_read_sequencer : reads 8 RTC time/date registers per tick, bursts them out.
// Optional RTC_TRANSFER_EN: prefix each read with a 0xF0 command write.
// Rev 1.0
// ---------------------------------------------------------------------------
module rtc_read_sequencer #(
    parameter int unsigned PHASE_CYCLES = 10,
    parameter logic [7:0]  BASE_ADDR    = 8'h21,
    parameter int unsigned HOLD_CYCLES  = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    rtc_read_sequencer_if.master  bus
);

    localparam logic [7:0] c_PHASE_LAST = 8'(PHASE_CYCLES - 1);
    localparam logic [7:0] c_EMIT_LAST  = 8'(8 + HOLD_CYCLES);
    localparam logic [7:0] c_CMD_ADDR   = 8'hF0;
`ifdef RTC_TRANSFER_EN
    localparam logic       c_TRANSFER   = 1'b1;
`else
    localparam logic       c_TRANSFER   = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_GAP_A = 3'd2,
        S_DATA  = 3'd3,
        S_GAP_D = 3'd4,
        S_EMIT  = 3'd5
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_ecnt;
    logic [2:0] r_idx;
    logic       r_pending;
    logic       r_cmd;
    logic [7:0] r_regs [8];

    logic [2:0] w_idx_next;
    logic [7:0] w_emit_byte;

    assign w_idx_next  = r_idx + 3'd1;
    assign w_emit_byte = (r_ecnt < 8'd8) ? r_regs[r_ecnt[2:0]] : r_regs[7];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state             <= S_IDLE;
            r_cnt               <= '0;
            r_ecnt              <= '0;
            r_idx               <= '0;
            r_pending           <= 1'b0;
            r_cmd               <= 1'b0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            bus.ad_o            <= '0;
            bus.ad_oe           <= 1'b0;
            bus.cs_n            <= 1'b1;
            bus.rd_n            <= 1'b1;
            bus.wr_n            <= 1'b1;
            bus.a_d             <= 1'b0;
            bus.busy            <= 1'b0;
            bus.inicioSecuencia <= 1'b0;
            bus.datoRTC         <= '0;
        end else begin
            // Ticks arriving mid-transaction collapse into a single pending request
            if (bus.tick && r_state != S_IDLE) r_pending <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (bus.tick || r_pending) begin
                        r_state   <= S_ADDR;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        r_pending <= 1'b0;
                        r_cmd     <= c_TRANSFER;
                        bus.busy  <= 1'b1;
                        bus.cs_n  <= 1'b0;
                        bus.wr_n  <= 1'b0;
                        bus.a_d   <= 1'b0;
                        bus.ad_oe <= 1'b1;
                        bus.ad_o  <= c_TRANSFER ? c_CMD_ADDR : BASE_ADDR;
                    end
                end
                S_ADDR: begin
                    if (r_cnt == c_PHASE_LAST) begin
                        r_state   <= S_GAP_A;
                        r_cnt     <= '0;
                        bus.cs_n  <= 1'b1;
                        bus.wr_n  <= 1'b1;
                        bus.ad_oe <= 1'b0;
                        bus.ad_o  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_GAP_A: begin
                    if (r_cnt == c_PHASE_LAST) begin
                        r_cnt <= '0;
                        if (r_cmd) begin
                            r_cmd     <= 1'b0;
                            r_state   <= S_ADDR;
                            bus.cs_n  <= 1'b0;
                            bus.wr_n  <= 1'b0;
                            bus.ad_oe <= 1'b1;
                            bus.ad_o  <= BASE_ADDR;
                        end else begin
                            r_state  <= S_DATA;
                            bus.cs_n <= 1'b0;
                            bus.rd_n <= 1'b0;
                            bus.a_d  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_PHASE_LAST) begin
                        r_regs[r_idx] <= bus.ad_i;
                        r_state       <= S_GAP_D;
                        r_cnt         <= '0;
                        bus.cs_n      <= 1'b1;
                        bus.rd_n      <= 1'b1;
                        bus.a_d       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_GAP_D: begin
                    if (r_cnt == c_PHASE_LAST) begin
                        r_cnt <= '0;
                        if (r_idx != 3'd7) begin
                            r_idx     <= w_idx_next;
                            r_state   <= S_ADDR;
                            bus.cs_n  <= 1'b0;
                            bus.wr_n  <= 1'b0;
                            bus.ad_oe <= 1'b1;
                            bus.ad_o  <= BASE_ADDR + {5'd0, w_idx_next};
                        end else begin
                            r_state             <= S_EMIT;
                            r_ecnt              <= '0;
                            bus.inicioSecuencia <= 1'b1;
                            bus.datoRTC         <= 8'h00;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_EMIT: begin
                    // Clock k of the burst shows regs[k-1]; the tail repeats the last register
                    if (r_ecnt == c_EMIT_LAST) begin
                        r_state             <= S_IDLE;
                        bus.inicioSecuencia <= 1'b0;
                        bus.busy            <= 1'b0;
                    end else begin
                        r_ecnt      <= r_ecnt + 8'd1;
                        bus.datoRTC <= w_emit_byte;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtc_read_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rtc_read_sequencer : directed vectors against an RTC bus model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rtc_read_sequencer;

    localparam int P = 2;
`ifdef RTC_TRANSFER_EN
    localparam int EXP_LAT = 32 * P + 1 + 2 * P;
    localparam int N_ADDR  = 9;
`else
    localparam int EXP_LAT = 32 * P + 1;
    localparam int N_ADDR  = 8;
`endif

    logic clk;
    logic reset;
    rtc_read_sequencer_if bus ();

    rtc_read_sequencer #(
        .PHASE_CYCLES (P),
        .BASE_ADDR    (8'h21),
        .HOLD_CYCLES  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RTC model: latch address on a write strobe, return table data on read strobe
    logic [7:0] rtc_data [8];
    logic [7:0] m_addr;
    logic [7:0] m_off;
    assign m_off    = m_addr - 8'h21;
    assign bus.ad_i = !bus.rd_n ? ((m_off < 8'd8) ? rtc_data[m_off[2:0]] : 8'hEE) : 8'hFF;

    always @(posedge clk) begin
        if (!bus.cs_n && !bus.wr_n && !bus.a_d) m_addr <= bus.ad_o;
    end

    int         n_vec = 0;
    int         n_err = 0;
    int         viol  = 0;
    int         pulse_len = 0;
    logic       prev_cs = 1'b1;
    logic [7:0] addr_q [$];

    always @(negedge clk) begin
        if (!reset) begin
            pulse_len = 0;
            prev_cs   = 1'b1;
        end else begin
            if (bus.ad_oe && !bus.rd_n) viol++;
            if (bus.a_d && bus.rd_n) viol++;
            if (bus.ad_oe != !bus.wr_n) viol++;
            if (!bus.cs_n && (bus.rd_n == bus.wr_n)) viol++;
            if (bus.cs_n && (!bus.rd_n || !bus.wr_n)) viol++;
            if (!bus.cs_n) begin
                if (prev_cs && !bus.wr_n) addr_q.push_back(bus.ad_o);
                pulse_len++;
            end else if (!prev_cs) begin
                if (pulse_len != P) viol++;
                pulse_len = 0;
            end
            prev_cs = bus.cs_n;
        end
    end

    typedef struct {
        logic [7:0] rtc [8];
        logic [7:0] exp_seq [12];
    } vec_t;
    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ad_o"},  32'(bus.ad_o), 32'h0);
        check({tag, "_ad_oe"}, 32'(bus.ad_oe), 32'h0);
        check({tag, "_cs_n"},  32'(bus.cs_n), 32'h1);
        check({tag, "_rd_n"},  32'(bus.rd_n), 32'h1);
        check({tag, "_wr_n"},  32'(bus.wr_n), 32'h1);
        check({tag, "_a_d"},   32'(bus.a_d), 32'h0);
        check({tag, "_busy"},  32'(bus.busy), 32'h0);
        check({tag, "_inicio"}, 32'(bus.inicioSecuencia), 32'h0);
        check({tag, "_dato"},  32'(bus.datoRTC), 32'h0);
    endtask

    // Called on the first negedge after the accepting edge; waits for and checks one burst
    task automatic wait_burst(input int r, input bit extra);
        int lat;
        lat = 1;
        while (bus.inicioSecuencia !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
            bus.tick = extra && (lat == 10 || lat == 20);
        end
        bus.tick = 1'b0;
        check("latency", 32'(lat), 32'(EXP_LAT));
        for (int k = 0; k < 12; k++) begin
            check($sformatf("inicio_k%0d", k), 32'(bus.inicioSecuencia), 32'h1);
            check($sformatf("dato_k%0d", k), 32'(bus.datoRTC), 32'(vecs[r].exp_seq[k]));
            @(negedge clk);
        end
        check("inicio_end", 32'(bus.inicioSecuencia), 32'h0);
        check("busy_end", 32'(bus.busy), 32'h0);
        check("dato_hold", 32'(bus.datoRTC), 32'(vecs[r].exp_seq[11]));
        check("addr_count", 32'(addr_q.size()), 32'(N_ADDR));
        if (addr_q.size() == N_ADDR) begin
            for (int a = 0; a < N_ADDR; a++) begin
                logic [7:0] ea;
                if (N_ADDR == 9) ea = (a == 0) ? 8'hF0 : 8'(8'h20 + a);
                else             ea = 8'(8'h21 + a);
                check($sformatf("addr_%0d", a), 32'(addr_q[a]), 32'(ea));
            end
        end
        addr_q.delete();
    endtask

    task automatic start_read(input int r, input bit extra);
        for (int i = 0; i < 8; i++) rtc_data[i] = vecs[r].rtc[i];
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        check("busy_on_accept", 32'(bus.busy), 32'h1);
        wait_burst(r, extra);
    endtask

    initial begin
        int cnt_hi;
        int guard;

        vecs[0].rtc     = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[0].exp_seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                            8'h08, 8'h08, 8'h08, 8'h08};
        vecs[1].rtc     = '{8'h24, 8'h04, 8'h03, 8'h23, 8'h12, 8'h17, 8'h05, 8'h04};
        vecs[1].exp_seq = '{8'h00, 8'h24, 8'h04, 8'h03, 8'h23, 8'h12, 8'h17, 8'h05,
                            8'h04, 8'h04, 8'h04, 8'h04};
        vecs[2].rtc     = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hC3};
        vecs[2].exp_seq = '{8'h00, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01,
                            8'hC3, 8'hC3, 8'hC3, 8'hC3};

        for (int i = 0; i < 8; i++) rtc_data[i] = 8'h00;
        bus.tick = 1'b0;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_init");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            start_read(v, 1'b0);
            repeat (3) @(negedge clk);
        end

        // Two ticks during busy: exactly one follow-up read, one idle cycle later
        start_read(1, 1'b1);
        @(negedge clk);
        check("pending_restart", 32'(bus.busy), 32'h1);
        wait_burst(1, 1'b0);
        repeat (30) @(negedge clk);
        check("third_tick_ignored", 32'(bus.busy), 32'h0);

        // Reset during the DATA phase of register 3
        for (int i = 0; i < 8; i++) rtc_data[i] = vecs[0].rtc[i];
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        guard = 0;
        while (!(bus.rd_n == 1'b0 && addr_q.size() > 0 && addr_q[addr_q.size() - 1] == 8'h24)
               && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("reach_data3", 32'(guard < 2000), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        repeat (4) @(negedge clk);
        reset = 1'b1;
        addr_q.delete();
        cnt_hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.inicioSecuencia || bus.busy) cnt_hi++;
        end
        check("no_burst_after_rst", 32'(cnt_hi), 32'h0);

        // Tick on the reset edge is lost
        reset    = 1'b0;
        bus.tick = 1'b1;
        @(negedge clk);
        reset    = 1'b1;
        bus.tick = 1'b0;
        repeat (10) @(negedge clk);
        check("tick_with_reset", 32'(bus.busy), 32'h0);

        check("bus_rules", 32'(viol), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
